// File: rtl/axis_stream_join_pkg.sv
// ---------------------------------------------------------------------------
// axis_stream_join_pkg
//   Shared parameters for the pixel/weight join path: TUSER field layout of
//   the weight stream and the output skid-buffer state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package axis_stream_join_pkg;

    // Weight-stream TUSER layout (bit indices).
    localparam int TUSER_WIDTH_DEF = 8;
    localparam int TUSER_SKIP_BIT  = 0;  // 1 = weight-only beat (config / bias)
    localparam int TUSER_SOF_BIT   = 1;  // first beat of a frame
    localparam int TUSER_EOL_BIT   = 2;  // end of line marker

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
//   Two-entry output buffer. Acceptance (o_space) is a pure function of the
//   registered state, so there is no combinational path from i_ready back to
//   the producer. Output data comes straight from a register (r_head).
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   i_push          producer writes i_data this cycle (only when o_space)
//   i_data          entry payload
//   o_space         buffer not FULL
//   o_valid/i_ready consumer handshake
//   o_data          head entry
// ---------------------------------------------------------------------------
module axis_skid_buffer
    import axis_stream_join_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_space,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    skid_state_e           r_state;
    skid_state_e           w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  w_pop;

    assign o_valid = (r_state != SKID_EMPTY);
    assign o_space = (r_state != SKID_FULL);
    assign o_data  = r_head;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= SKID_EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SKID_EMPTY: if (i_push)           w_state_nxt = SKID_ONE;
            SKID_ONE: begin
                if (i_push && !w_pop)         w_state_nxt = SKID_FULL;
                else if (!i_push && w_pop)    w_state_nxt = SKID_EMPTY;
            end
            SKID_FULL:  if (w_pop)            w_state_nxt = SKID_ONE;
            default:                          w_state_nxt = SKID_EMPTY;
        endcase
    end

    // Head always holds the oldest entry; tail only used while FULL.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                SKID_EMPTY: if (i_push) r_head <= i_data;
                SKID_ONE: begin
                    if (i_push && w_pop) r_head <= i_data;
                    else if (i_push)     r_tail <= i_data;
                end
                SKID_FULL:  if (w_pop)  r_head <= r_tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_stream_join.sv
// ---------------------------------------------------------------------------
// axis_stream_join
//   Joins one weight stream with NUM_PX pixel streams into one registered
//   output beat. A weight beat with w_user[USER_SKIP] set is weight-only:
//   it consumes no pixels and emits zero pixels. Pixel tlast disagreement on
//   a joined beat raises sticky err_last (beat still passes through).
// Ports
//   aclk, aresetn                  clock, asynchronous active-low reset
//   w_valid/w_ready/w_last/w_user/w_data   weight stream
//   px_valid/px_ready/px_last/px_data      NUM_PX pixel streams
//   m_valid/m_ready/m_last/m_user/m_pixels/m_weights  joined output
//   err_last, err_clear            sticky tlast error and its clear
// Optional (macro AXIS_JOIN_PERF_EN):
//   perf_beats, perf_px_stall, perf_out_stall  saturating 32-bit counters
// ---------------------------------------------------------------------------
module axis_stream_join
    import axis_stream_join_pkg::*;
#(
    parameter int NUM_PX      = 2,
    parameter int ROWS        = 8,
    parameter int COLS        = 24,
    parameter int WORD_WIDTH  = 8,
    parameter int TUSER_WIDTH = TUSER_WIDTH_DEF,
    parameter int USER_SKIP   = TUSER_SKIP_BIT
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic                               w_last,
    input  logic [TUSER_WIDTH-1:0]             w_user,
    input  logic [COLS*WORD_WIDTH-1:0]         w_data,
    input  logic [NUM_PX-1:0]                  px_valid,
    output logic [NUM_PX-1:0]                  px_ready,
    input  logic [NUM_PX-1:0]                  px_last,
    input  logic [NUM_PX*ROWS*WORD_WIDTH-1:0]  px_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_last,
    output logic [TUSER_WIDTH-1:0]             m_user,
    output logic [NUM_PX*ROWS*WORD_WIDTH-1:0]  m_pixels,
    output logic [COLS*WORD_WIDTH-1:0]         m_weights,
    output logic                               err_last,
    input  logic                               err_clear
`ifdef AXIS_JOIN_PERF_EN
    ,
    output logic [31:0]                        perf_beats,
    output logic [31:0]                        perf_px_stall,
    output logic [31:0]                        perf_out_stall
`endif
);

    localparam int PX_W   = ROWS * WORD_WIDTH;
    localparam int PXS_W  = NUM_PX * PX_W;
    localparam int WT_W   = COLS * WORD_WIDTH;
    localparam int BEAT_W = 1 + TUSER_WIDTH + PXS_W + WT_W;

    logic              w_skip;
    logic              w_space;
    logic              w_fire;
    logic              w_last_bad;
    logic [PXS_W-1:0]  w_px_in;
    logic [BEAT_W-1:0] w_beat_in;
    logic [BEAT_W-1:0] w_beat_out;
    logic              r_err_last;

    assign w_skip = w_user[USER_SKIP];

    // Join: weight beat plus either all pixel streams or none. Gated by
    // aresetn so readies are held low throughout reset.
    assign w_fire  = aresetn & w_valid & w_space & (w_skip | (&px_valid));
    assign w_ready = w_fire;

    // Per-stream ready and pixel gating (weight-only beats carry zero pixels).
    for (genvar gi = 0; gi < NUM_PX; gi++) begin : g_px
        assign px_ready[gi]               = w_fire & ~w_skip;
        assign w_px_in[gi*PX_W +: PX_W]   = w_skip ? '0 : px_data[gi*PX_W +: PX_W];
    end

    // Pixel tlasts must all agree: all set or all clear.
    assign w_last_bad = ~((&px_last) | ~(|px_last));

    assign w_beat_in = {w_last, w_user, w_px_in, w_data};

    axis_skid_buffer #(
        .DATA_WIDTH (BEAT_W)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (w_fire),
        .i_data  (w_beat_in),
        .o_space (w_space),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (w_beat_out)
    );

    assign {m_last, m_user, m_pixels, m_weights} = w_beat_out;

    // Sticky tlast error; clear has priority over a same-cycle set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                             r_err_last <= 1'b0;
        else if (err_clear)                       r_err_last <= 1'b0;
        else if (w_fire && !w_skip && w_last_bad) r_err_last <= 1'b1;
    end
    assign err_last = r_err_last;

`ifdef AXIS_JOIN_PERF_EN
    logic [31:0] r_perf_beats;
    logic [31:0] r_perf_px_stall;
    logic [31:0] r_perf_out_stall;
    logic        w_px_stall;
    logic        w_out_stall;

    assign w_px_stall  = w_valid & ~w_skip & ~(&px_valid) & w_space;
    assign w_out_stall = m_valid & ~m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_perf_beats     <= '0;
            r_perf_px_stall  <= '0;
            r_perf_out_stall <= '0;
        end else if (err_clear) begin
            r_perf_beats     <= '0;
            r_perf_px_stall  <= '0;
            r_perf_out_stall <= '0;
        end else begin
            if (w_fire && r_perf_beats != 32'hFFFF_FFFF)
                r_perf_beats <= r_perf_beats + 32'd1;
            if (w_px_stall && r_perf_px_stall != 32'hFFFF_FFFF)
                r_perf_px_stall <= r_perf_px_stall + 32'd1;
            if (w_out_stall && r_perf_out_stall != 32'hFFFF_FFFF)
                r_perf_out_stall <= r_perf_out_stall + 32'd1;
        end
    end

    assign perf_beats     = r_perf_beats;
    assign perf_px_stall  = r_perf_px_stall;
    assign perf_out_stall = r_perf_out_stall;
`endif

endmodule

// File: tb/tb_axis_stream_join.sv
module tb_axis_stream_join;

    localparam int NPX  = 2;
    localparam int PXW  = NPX * 8 * 8;
    localparam int WTW  = 24 * 8;
    localparam int BW   = 1 + 8 + PXW + WTW;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b1;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic             w_last = 1'b0;
    logic [7:0]       w_user = '0;
    logic [WTW-1:0]   w_data = '0;
    logic [NPX-1:0]   px_valid = '0;
    logic [NPX-1:0]   px_ready;
    logic [NPX-1:0]   px_last = '0;
    logic [PXW-1:0]   px_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
    logic [7:0]       m_user;
    logic [PXW-1:0]   m_pixels;
    logic [WTW-1:0]   m_weights;
    logic             err_last;
    logic             err_clear = 1'b0;

    axis_stream_join #(
        .NUM_PX(NPX), .ROWS(8), .COLS(24), .WORD_WIDTH(8), .TUSER_WIDTH(8), .USER_SKIP(0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_user(w_user), .w_data(w_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last), .px_data(px_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_user(m_user),
        .m_pixels(m_pixels), .m_weights(m_weights),
        .err_last(err_last), .err_clear(err_clear)
    );

    always #5 aclk = ~aclk;

    int             ncmp = 0;
    int             nerr = 0;
    int             nout = 0;
    int             mcnt = 0;
    logic           merr = 1'b0;
    logic           fire_seen = 1'b0;
    logic [BW-1:0]  sb[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: skid occupancy, join rule, sticky error, scoreboard.
    always @(negedge aclk) begin
        logic mfire, mpop, skip;
        logic [BW-1:0] exp_b;
        if (!aresetn) begin
            mcnt = 0;
            merr = 1'b0;
            fire_seen = 1'b0;
            sb.delete();
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_beat", {m_last, m_user, m_pixels, m_weights}, 0);
            chk("rst_err", err_last, 0);
            chk("rst_w_ready", w_ready, 0);
            chk("rst_px_ready", px_ready, 0);
        end else begin
            skip  = w_user[0];
            mfire = w_valid && (mcnt < 2) && (skip || (&px_valid));
            mpop  = (mcnt > 0) && m_ready;
            chk("m_valid", m_valid, mcnt > 0);
            chk("w_ready", w_ready, mfire);
            chk("px_ready", px_ready, (mfire && !skip) ? 2'b11 : 2'b00);
            chk("err_last", err_last, merr);
            if (mpop) begin
                if (sb.size() == 0) exp_b = 'x;
                else                exp_b = sb.pop_front();
                chk("beat", {m_last, m_user, m_pixels, m_weights}, exp_b);
                nout++;
            end
            if (mfire)
                sb.push_back({w_last, w_user, skip ? {PXW{1'b0}} : px_data, w_data});
            if (err_clear) merr = 1'b0;
            else if (mfire && !skip && !((&px_last) || !(|px_last))) merr = 1'b1;
            mcnt = mcnt + int'(mfire) - int'(mpop);
            fire_seen = mfire;
        end
    end

    task automatic new_beat(input logic skip, input logic last);
        w_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w_user = (8'($urandom()) & 8'hFE) | {7'd0, skip};
        w_last = last;
        px_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        w_valid = 1'b1;
    endtask

    // Wait (bounded) for the model to see the presented beat taken.
    task automatic wait_fire(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge aclk);
            cyc++;
        end while (!fire_seen && cyc < 50);
        chk(tag, fire_seen, 1);
        #1;
    endtask

    initial begin
        int cyc, tot;
        logic [WTW-1:0] saved_w;
        #1 aresetn = 1'b0;
        w_valid = 1'b1;  // must be ignored during reset
        px_valid = 2'b11;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        w_valid = 1'b0;
        @(posedge aclk); #1;

        // 1: streaming, 16 beats, no bubbles
        m_ready = 1'b1;
        px_valid = 2'b11;
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            new_beat(1'b0, i == 15);
            wait_fire("t1_fire", cyc);
            tot += cyc;
        end
        chk("t1_cycles", tot, 16);
        chk("t1_m_valid", m_valid, 1);
        w_valid = 1'b0;
        repeat (3) @(posedge aclk);
        #1 chk("t1_nout", nout, 16);

        // 2: partial pixel valid holds everything
        new_beat(1'b0, 1'b0);
        px_valid = 2'b01;
        repeat (5) begin
            @(posedge aclk); #2;
            chk("t2_w_ready", w_ready, 0);
            chk("t2_px_ready", px_ready, 2'b00);
        end
        px_valid = 2'b11;
        wait_fire("t2_fire", cyc);
        chk("t2_latency", cyc, 1);
        w_valid = 1'b0;
        repeat (2) @(posedge aclk); #1;

        // 3: weight-only beat, then the same pixels joined to the next weight
        new_beat(1'b1, 1'b0);
        #1 chk("t3_px_ready", px_ready, 2'b00);
        chk("t3_w_ready", w_ready, 1);
        wait_fire("t3_fire_skip", cyc);
        w_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w_user = 8'h40;
        wait_fire("t3_fire_px", cyc);
        w_valid = 1'b0;
        repeat (3) @(posedge aclk); #1;

        // 4: backpressure, exactly two accepted, FIFO drain
        m_ready = 1'b0;
        new_beat(1'b0, 1'b0);
        wait_fire("t4_fire0", cyc);
        new_beat(1'b0, 1'b1);
        wait_fire("t4_fire1", cyc);
        new_beat(1'b0, 1'b0);
        repeat (3) begin
            @(posedge aclk); #2;
            chk("t4_w_ready", w_ready, 0);
            chk("t4_m_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        wait_fire("t4_fire2", cyc);
        w_valid = 1'b0;
        repeat (4) @(posedge aclk); #1;

        // 5: tlast mismatch, sticky until cleared
        px_last = 2'b10;
        new_beat(1'b0, 1'b0);
        wait_fire("t5_fire", cyc);
        px_last = 2'b00;
        w_valid = 1'b0;
        repeat (3) begin
            @(posedge aclk); #2;
            chk("t5_err_hold", err_last, 1);
        end
        err_clear = 1'b1;
        @(posedge aclk); #1;
        err_clear = 1'b0;
        #1 chk("t5_err_clr", err_last, 0);
        @(posedge aclk); #1;

        // 6: reset with FULL buffer drops both entries
        m_ready = 1'b0;
        new_beat(1'b0, 1'b0);
        wait_fire("t6_fire0", cyc);
        new_beat(1'b0, 1'b0);
        wait_fire("t6_fire1", cyc);
        new_beat(1'b0, 1'b0);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1 chk("t6_m_valid", m_valid, 0);
        chk("t6_w_ready", w_ready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_ready = 1'b1;
        new_beat(1'b0, 1'b1);
        saved_w = w_data;
        wait_fire("t6_fire_new", cyc);
        w_valid = 1'b0;
        #1 chk("t6_first", m_weights, saved_w);
        repeat (4) @(posedge aclk); #1;

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
